// File: rtl/dsa_run_ctrl_if.sv
// Start/done handshake, clear-path and status bundle between the DSA run controller and its neighbours.
interface dsa_run_ctrl_if #(parameter int AW = 12);
  logic          start_req;
  logic          clear_req;
  logic          mode_simd_in;
  logic          seq_done;
  logic          simd_done;
  logic          seq_start;
  logic          simd_start;
  logic          mode_simd;
  logic          clr_active;
  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          busy;
  logic          done;
  logic          err_timeout;
  logic          in_we_allow;
  logic [31:0]   run_cycles;

  modport master (
    output start_req, clear_req, mode_simd_in, seq_done, simd_done,
    input  seq_start, simd_start, mode_simd, clr_active, clr_we, clr_addr,
           busy, done, err_timeout, in_we_allow, run_cycles
  );

  modport slave (
    input  start_req, clear_req, mode_simd_in, seq_done, simd_done,
    output seq_start, simd_start, mode_simd, clr_active, clr_we, clr_addr,
           busy, done, err_timeout, in_we_allow, run_cycles
  );
endinterface

// File: rtl/dsa_run_ctrl.sv
// DSA run controller: output-BRAM clear sweep, core start/done handshake, mode latch, run-time counter.
// Optional watchdog enabled by defining RUN_CTRL_TIMEOUT_EN.
module dsa_run_ctrl #(
  parameter int AW        = 12,
  parameter int TIMEOUT_W = 24
) (
  input logic           clk_50,
  input logic           rst,
  dsa_run_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_LAUNCH, S_RUN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] clr_addr_q;
  logic          clr_we_q;
  logic          pending;
  logic          mode_q;
  logic          done_q;
  logic          err_q;
  logic          seq_start_q;
  logic          simd_start_q;
  logic [31:0]   cnt;
  logic [31:0]   run_cycles_q;
  logic          accept;
  logic          clear_go;
  logic          core_done;
  logic          timeout_hit;
  logic          busy_c;
  logic          idle_c;
  logic          clr_active_c;

  assign core_done = mode_q ? bus.simd_done : bus.seq_done;

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) state <= S_CLEAR;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    clear_go  = 1'b0;
    case (state)
      S_CLEAR:  if (&clr_addr_q) state_nxt = S_IDLE;
      S_IDLE: begin
        // clear beats a simultaneous start; the start survives as pending
        if (bus.clear_req) begin
          clear_go  = 1'b1;
          state_nxt = S_CLEAR;
        end else if (bus.start_req || pending) begin
          accept    = 1'b1;
          state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: state_nxt = S_RUN;
      S_RUN:    if (core_done || timeout_hit) state_nxt = S_IDLE;
      default:  state_nxt = S_CLEAR;
    endcase
  end

  always_comb begin
    busy_c       = (state != S_IDLE);
    idle_c       = (state == S_IDLE);
    clr_active_c = (state == S_CLEAR);
  end

`ifdef RUN_CTRL_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wdog;

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst)                   wdog <= '0;
    else if (state == S_LAUNCH) wdog <= '0;
    else if (state == S_RUN)    wdog <= wdog + TIMEOUT_W'(1);
  end

  // fires on the edge where the watchdog would reach all-ones
  assign timeout_hit = (state == S_RUN) && (wdog == {{(TIMEOUT_W-1){1'b1}}, 1'b0});
`else
  assign timeout_hit = 1'b0 && (TIMEOUT_W > 0);
`endif

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      clr_addr_q   <= '0;
      clr_we_q     <= 1'b1;
      pending      <= 1'b0;
      mode_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      seq_start_q  <= 1'b0;
      simd_start_q <= 1'b0;
      cnt          <= '0;
      run_cycles_q <= '0;
    end else begin
      seq_start_q  <= accept && !bus.mode_simd_in;
      simd_start_q <= accept && bus.mode_simd_in;
      clr_we_q     <= (state_nxt == S_CLEAR);

      // wraps back to 0 on the last sweep cycle
      if (state == S_CLEAR) clr_addr_q <= clr_addr_q + AW'(1);

      if ((state == S_CLEAR || clear_go) && bus.start_req) pending <= 1'b1;
      else if (accept)                                      pending <= 1'b0;

      if (accept) begin
        mode_q <= bus.mode_simd_in;
        done_q <= 1'b0;
        err_q  <= 1'b0;
        cnt    <= 32'd1;
      end else if ((state == S_LAUNCH || state == S_RUN) && cnt != 32'hFFFF_FFFF) begin
        cnt <= cnt + 32'd1;
      end

      if (clear_go) done_q <= 1'b0;

      if (state == S_RUN && core_done) begin
        run_cycles_q <= cnt;
        done_q       <= 1'b1;
      end else if (timeout_hit) begin
        run_cycles_q <= cnt;
        err_q        <= 1'b1;
      end
    end
  end

  assign bus.seq_start   = seq_start_q;
  assign bus.simd_start  = simd_start_q;
  assign bus.mode_simd   = mode_q;
  assign bus.clr_active  = clr_active_c;
  assign bus.clr_we      = clr_we_q;
  assign bus.clr_addr    = clr_addr_q;
  assign bus.busy        = busy_c;
  assign bus.done        = done_q;
  assign bus.err_timeout = err_q;
  assign bus.in_we_allow = idle_c;
  assign bus.run_cycles  = run_cycles_q;

endmodule

// File: doc/dsa_run_ctrl.md
# dsa_run_ctrl

Run controller for the bilinear DSA: owns the start/done handshake with the sequential and SIMD cores, latches the execution mode for the duration of a job, and sequences the post-reset (or on-demand) zero fill of the output BRAM. It sits between the start sources (debounced switch and JTAG) and the two cores. It also sits in front of the output-memory write mux, and provides a cycle-accurate run-time counter and status flags for the JTAG status path.

## Interface
- `AW`, 12: BRAM address width; the clear sweep covers 2^AW words.
- `TIMEOUT_W`, 24: watchdog counter width.
- `clk_50` in 1: single system clock.
- `rst` in 1: asynchronous, active-high reset.
- `start_req` in 1: one-cycle start request, already OR-ed from switch and JTAG.
- `clear_req` in 1: one-cycle request to re-zero the output BRAM.
- `mode_simd_in` in 1: requested mode, 1 = SIMD; sampled only on start acceptance.
- `seq_done`, `simd_done` in 1 each: one-cycle done pulses from the cores.
- `seq_start`, `simd_start` out 1 each: one-cycle start pulses to the cores.
- `mode_simd` out 1: latched mode; drives the core read/write/perf muxes.
- `clr_active` out 1: clear sweep in progress; selects the clear path in the output write mux.
- `clr_we` out 1: write enable for the clear path.
- `clr_addr` out AW: address for the clear path; the write data is always 8'h00.
- `busy` out 1: high when the state is not IDLE.
- `done` out 1: sticky job-complete flag.
- `err_timeout` out 1: sticky watchdog flag.
- `in_we_allow` out 1: input-BRAM JTAG writes permitted; equals state==IDLE.
- `run_cycles` out 32: cycle count of the last completed job.

## Operation
- States: CLEAR, IDLE, LAUNCH, RUN.
- Reset behaviour:
  - State goes to CLEAR.
  - `clr_addr`=0, `mode_simd`=0, `done`=0, `err_timeout`=0, `run_cycles`=0, `pending`=0.
  - Start pulses are 0.
- CLEAR:
  - `clr_active`=`clr_we`=1 and `clr_addr` increments each cycle.
  - After the cycle with `clr_addr`=2^AW-1, the state goes to IDLE and `clr_addr` wraps to 0.
  - The sweep takes exactly 2^AW cycles.
- `start_req` during CLEAR sets a one-deep `pending` bit. Further requests merge into it.
- IDLE:
  - On `start_req` or `pending`, latch `mode_simd`←`mode_simd_in`, clear `done`/`err_timeout`/`pending`, and load cnt←1.
  - The state goes to LAUNCH.
  - The selected start output is registered high.
- LAUNCH: lasts exactly one cycle. The selected start is high and the other is low. The state goes to RUN and cnt increments.
- RUN:
  - cnt increments every cycle.
  - On the done pulse of the latched core: `run_cycles`←cnt, `done`←1, state goes to IDLE.
  - A done pulse from the non-selected core is ignored.
- `start_req` in LAUNCH or RUN is dropped; it does not set `pending`.
- `clear_req`:
  - In IDLE, goes to CLEAR and clears `done`.
  - In other states it is ignored.
  - If `start_req` and `clear_req` arrive together in IDLE, the clear wins and the start becomes `pending`.
- `mode_simd_in` changes outside start acceptance have no effect. `mode_simd` is stable through LAUNCH/RUN and retains its value in IDLE.
- cnt saturates at 2^32-1 and does not wrap.

## Timing
- If `start_req` is high in cycle t while in IDLE, the start pulse is high in cycle t+1 only and `busy` rises in t+1.
- If the core `done` is in cycle t+1+k, then `run_cycles`=k+1, and `done`=1 and `busy`=0 from cycle t+2+k.
- A pending start launches the cycle after CLEAR exits: the start pulse occurs 2^AW+1 cycles after reset release.
- All outputs are registered, except `busy`, `in_we_allow` and `clr_active`, which decode directly from the state register.
- Asserting `rst` mid-run aborts immediately to the reset values, and a full clear sweep follows. The cores are reset by the same signal.

## Configuration
- `RUN_CTRL_TIMEOUT_EN` defined:
  - A TIMEOUT_W-bit watchdog is cleared on LAUNCH and increments in RUN.
  - When it reaches 2^TIMEOUT_W-1 without a matching done, set `err_timeout`=1, leave `done`=0, set `run_cycles`←cnt, and go to IDLE.
  - A late done arriving afterwards is ignored.
- Undefined: no watchdog logic, RUN waits indefinitely, and `err_timeout` is tied to 0.

## Test plan
All scenarios use AW=4 and TIMEOUT_W=6.
- Reset released at cycle 0: `clr_we`=1 with addresses 0..15 in cycles 0..15, and `busy`=0 from cycle 16.
- `start_req` at cycle 3 during CLEAR with `mode_simd_in`=1: `simd_start` is a single pulse at cycle 17 and `seq_start` never pulses.
- IDLE start with mode 0 and `seq_done` 9 cycles after `seq_start`: `run_cycles`=10 and `done`=1. A `simd_done` injected mid-run is ignored, and a second `start_req` in RUN produces no extra start.
- Toggle `mode_simd_in` during RUN: `mode_simd` holds. `clear_req` together with `start_req` in IDLE: a 16-cycle sweep, then the launch.
- With `RUN_CTRL_TIMEOUT_EN`, no done is returned: `err_timeout`=1 and `done`=0 after 63 RUN cycles. A later `seq_done` changes nothing, and the next start clears `err_timeout`.
- Assert `rst` in RUN: outputs go to reset values immediately, and the clear sweep restarts from address 0.
